alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side driver for the Datapath: accepts packed ALU instructions over a valid/ready handshake,
//  decodes them and drives wr/ALUControl/addr1..3 for one execute cycle, then captures the returned Zero.
//  Sits between a host/test source and Datapath; provides retire pulse, zero flag, illegal flag, retire count.
// PARAMETERS
//  ADDR_W   2   register address width (matches 4-entry regfile)
//  CNT_W    16  width of retired-instruction counter
//  INSTR_W  11  instruction width: [10] skip_if_zero, [9] nowb, [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst          in   1        asynchronous, active-low reset
//  instr_valid  in   1        instruction offered
//  instr_ready  out  1        sequencer can accept (IDLE only)
//  instr        in   INSTR_W  packed instruction, sampled on valid&&ready edge
//  wr           out  1        Datapath register write enable
//  ALUControl   out  3        Datapath ALU op
//  addr1/addr2  out  ADDR_W   Datapath read addresses (rs1/rs2)
//  addr3        out  ADDR_W   Datapath write address (rd)
//  Zero         in   1        Datapath Zero (combinational from addr/ALUControl)
//  busy         out  1        1 in any state but IDLE
//  done         out  1        1-cycle pulse in RETIRE
//  zero_flag    out  1        last captured Zero
//  illegal      out  1        1-cycle pulse with done when op not in {000,001,010,011,101}
//  retired_cnt  out  CNT_W    count of retired instructions
// BEHAVIOUR
//  Reset (rst=0): state=IDLE; wr, done, illegal, zero_flag, busy=0; ALUControl, addr1..3=0; retired_cnt=0;
//   instr_ready=0 while rst low, 1 from first edge after release. Reset mid-operation drops wr immediately; no write.
//  FSM: IDLE -(valid&&ready)-> DECODE -> EXEC -> RETIRE -> IDLE. No other transitions; 4 cycles/instr.
//  IDLE: ready=1; valid without ready never latched; instr need only be stable on the accepting edge.
//  DECODE: instr register loaded; addr1=rs1, addr2=rs2, addr3=rd, ALUControl=op (000 if illegal);
//   these outputs held stable from DECODE through RETIRE and keep their values in IDLE.
//  EXEC: wr=1 for exactly this cycle iff op legal && !nowb && !skip; Zero sampled into zero_flag at end of EXEC
//   iff op legal && !skip (nowb = compare-only: flag updates, no write).
//  RETIRE: done=1; illegal=1 if op illegal; retired_cnt+=1 for every instr (legal, illegal, skipped); wraps 2^CNT_W-1 -> 0.
//  Illegal op: no write, zero_flag unchanged.
// CONFIGURATION
//  SEQ_ZERO_SKIP_EN defined: skip = instr[10] && zero_flag (value at DECODE, from previous instr);
//   skipped instr: wr=0, zero_flag unchanged, still retires (done, count).
//  Not defined: instr[10] ignored, skip forced 0; all legal, !nowb instrs write.
// STRUCTURE
//  Package alu_seq_pkg: op constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_XOR=011, OP_SLT=101;
//   state enum {IDLE,DECODE,EXEC,RETIRE}; INSTR_W and instr field bit positions.
//  Sub-module alu_op_decode: combinational op legality check and ALUControl mapping.
//  Top: FSM, instruction register, zero_flag, retired_cnt; instantiated beside Datapath in the bench.
// TESTING
//  Reset held low -> wr=0, done=0, instr_ready=0, retired_cnt=0; release -> instr_ready=1 next cycle.
//  r1=5, r2=7; ADD rd=3 rs1=1 rs2=2 -> wr=1 only in EXEC with addr3=3, r3=12, zero_flag=0, done 3 cycles after accept, cnt=1.
//  SUB rd=0 rs1=1 rs2=1 -> r0=0, zero_flag=1; then SUB nowb rs1=1 rs2=2 -> wr never 1, zero_flag=0.
//  op=110 -> no wr, illegal and done pulse together, zero_flag unchanged, cnt increments.
//  valid held high for 3 instrs -> accepted every 4 cycles, ready low 3 cycles between; rst low during EXEC -> wr=0 at once, rd unchanged.
//  SEQ_ZERO_SKIP_EN: after zero result, skip-bit ADD -> no write, done pulses; macro undefined -> same instr writes.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: opcodes, FSM states, instruction field layout.
// Optional SEQ_ZERO_SKIP_EN build enables skip-if-zero instructions in alu_op_sequencer.
package alu_seq_pkg;

  localparam int INSTR_W  = 11;
  localparam int SKIP_BIT = 10;
  localparam int NOWB_BIT = 9;
  localparam int OP_LO    = 6;
  localparam int RD_LO    = 4;
  localparam int RS1_LO   = 2;
  localparam int RS2_LO   = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    RETIRE = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode legality check and ALUControl mapping; illegal ops map to the ADD encoding.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op_i,
  output logic       legal_o,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    legal_o    = op_is_legal(op_i);
    alu_ctrl_o = legal_o ? op_i : OP_ADD;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one packed ALU instruction through DECODE/EXEC/RETIRE towards the Datapath.
// Build with SEQ_ZERO_SKIP_EN defined to honour the skip-if-zero instruction bit.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int CNT_W   = 16,
  parameter int INSTR_W = alu_seq_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               wr,
  output logic [2:0]         ALUControl,
  output logic [ADDR_W-1:0]  addr1,
  output logic [ADDR_W-1:0]  addr2,
  output logic [ADDR_W-1:0]  addr3,
  input  logic               Zero,
  output logic               busy,
  output logic               done,
  output logic               zero_flag,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired_cnt,
  output state_e             dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE and only once reset has been released for an edge.
  state_e             state_q, state_d;
  logic               alive_q;
  logic [INSTR_W-1:0] instr_q;
  logic               skip_q, skip_d;
  logic               zero_flag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               legal;
  logic               accept;

  alu_op_decode u_decode (
    .op_i       (instr_q[OP_LO +: 3]),
    .legal_o    (legal),
    .alu_ctrl_o (ALUControl)
  );

`ifdef SEQ_ZERO_SKIP_EN
  // Skip decision uses the flag left by the previous instruction.
  assign skip_d = instr[SKIP_BIT] & zero_flag_q;
`else
  logic unused_skip_bit;
  assign unused_skip_bit = instr[SKIP_BIT];
  assign skip_d          = 1'b0;
`endif

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    busy        = 1'b1;
    wr          = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        busy        = 1'b0;
        instr_ready = alive_q;
        if (accept) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        wr      = legal && !instr_q[NOWB_BIT] && !skip_q;
        state_d = RETIRE;
      end
      RETIRE: begin
        done    = 1'b1;
        illegal = !legal;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      alive_q     <= 1'b0;
      instr_q     <= '0;
      skip_q      <= 1'b0;
      zero_flag_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        instr_q <= instr;
        skip_q  <= skip_d;
      end
      // Compare-only (nowb) instructions still update the flag.
      if (state_q == EXEC && legal && !skip_q) zero_flag_q <= Zero;
      if (state_q == RETIRE) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign addr1       = instr_q[RS1_LO +: ADDR_W];
  assign addr2       = instr_q[RS2_LO +: ADDR_W];
  assign addr3       = instr_q[RD_LO +: ADDR_W];
  assign zero_flag   = zero_flag_q;
  assign retired_cnt = cnt_q;
  assign dbg_state   = state_q;

endmodule
